frac_div: RTL and testbench
===========================

Name: frac_div

Overview:
- Iterative restoring divider that sits directly downstream of the integer square-root stage.
- Computes a fixed-point ratio (num << FRAC) / den, e.g. a component divided by sqrt(a^2+b^2), giving a Q.FRAC direction cosine.
- Uses the same start/state handshake as the square and root stages, so a controller or bench can chain it by polling state_o.
- Produces one quotient bit per clock.

Parameters:
- WIDTH, 32, width of numerator and denominator operands.
- FRAC, 8, number of fractional quotient bits appended below the numerator.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-low.
- start_i  input  1  level start request, sampled only in IDLE.
- num_bi  input  WIDTH  unsigned numerator.
- den_bi  input  WIDTH  unsigned denominator (root stage y_bo).
- state_o  output  3  0=IDLE, 1=WORK, 2=DONE, 3=DIV0.
- q_bo  output  WIDTH+FRAC  unsigned quotient, Q(WIDTH).(FRAC).
- r_bo  output  WIDTH  remainder of (num << FRAC) mod den.

Behaviour:
- Reset (rst_i=0, async): state_o=0, q_bo=0, r_bo=0, internal counter=0, operand registers=0. Takes effect mid-operation with no completion.
- Let N = WIDTH+FRAC. Dividend D = {num_bi, FRAC'b0}, N bits.
- IDLE: on a clock edge with start_i=1, latch num_bi and den_bi.
  - If den_bi==0: go to DIV0.
  - Otherwise: go to WORK with counter=N-1, partial remainder=0, q register cleared.
  - Operand changes after the latch are ignored.
- WORK, one restoring step per clock, MSB of D first:
  - rem' = {rem, next D bit}; width is WIDTH+1 to hold the carry.
  - If rem' >= den: rem = rem' - den and the quotient bit is 1. Otherwise rem = rem' and the bit is 0.
  - Quotient bits shift into q from the LSB.
  - When counter==0: go to DONE. Otherwise decrement the counter.
- Latency: state_o==2 is visible on the N-th rising edge after the start edge (40 edges at defaults).
- q_bo/r_bo are undefined-but-stable (intermediate) during WORK. They are valid and held in DONE.
- DONE: hold q_bo, r_bo and state. Return to IDLE on the first edge with start_i=0.
  - start_i held high keeps DONE; no automatic relaunch.
  - A new operation requires start_i to deassert for at least one edge, then reassert.
- DIV0: q_bo = all ones (saturated), r_bo=0. Exit rules are identical to DONE.
- Boundaries:
  - num=0 gives q=0, r=0 after the full N cycles; no early exit.
  - den=1 gives q=D exactly.
  - num < den gives a fraction-only quotient.
  - A start asserted in the same cycle that reset releases is honoured on the next edge.

Optional Feature:
- FRAC_DIV_ROUND_EN defined:
  - DONE is entered one cycle later (latency N+1) via an extra ROUND cycle, internal only; state_o still reports 1 during it.
  - In the ROUND cycle, if 2*rem >= den, q increments (round half up). If q is already all ones it saturates and does not wrap.
  - r_bo still reports the unrounded remainder.
- Undefined: truncation only, latency N.

Decomposition:
- Package frac_div_pkg:
  - State localparams ST_IDLE=3'd0, ST_WORK=3'd1, ST_DONE=3'd2, ST_DIV0=3'd3.
  - A shared state-width constant, reusable by the square and root stages.
- Sub-module frac_div_step: a purely combinational single restoring step.
  - Inputs: rem, incoming bit, den.
  - Outputs: new rem, quotient bit.
  - The top holds only the FSM, counter and registers.

Test Plan:
- num=3, den=5, start pulse -> state_o=1 for 39 edges, then 2 on edge 40; q_bo=153 (0x99), r_bo=3. With FRAC_DIV_ROUND_EN: q_bo=154, latency 41.
- num=5, den=5 -> q_bo=256 (1.0 in Q.8), r_bo=0. num=0, den=7 -> q_bo=0, r_bo=0 after 40 edges.
- num=32'hFFFFFFFF, den=1 -> q_bo=40'hFFFFFFFF00, r_bo=0. With rounding enabled, check saturation on den=1, num=max: no increment.
- den=0, num=9 -> state_o=3 on the next edge, q_bo=40'hFFFFFFFFFF, r_bo=0.
  - Hold start_i=1: stays 3.
  - Drop start_i: returns to 0.
- Start num=3/den=5, assert rst_i=0 at edge 20 asynchronously (mid-cycle) -> state_o, q_bo, r_bo are 0 immediately. Release and restart num=4/den=5 -> q_bo=204, r_bo=4.
- Chain root(x=25) -> y=5 feeding den, num=3. Toggle start_i per handshake; hold start_i high through DONE -> no second launch; q_bo stays 153.

Source files
------------

// File: rtl/frac_div_pkg.sv
// rtl/frac_div_pkg.sv - shared state codes and helpers for the frac_div stage
// Purpose : state encodings visible on state_o (shared with the square and
//           root stages), the internal FSM enum and a counter-width helper.
// Ports   : none (package).
package frac_div_pkg;

   // Width of the state_o bus used by every stage of the chain.
   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
   localparam logic [STATE_W-1:0] ST_WORK = 3'd1;
   localparam logic [STATE_W-1:0] ST_DONE = 3'd2;
   localparam logic [STATE_W-1:0] ST_DIV0 = 3'd3;

   // FSM_ROUND is internal only; it is reported as ST_WORK on state_o.
   typedef enum logic [STATE_W-1:0] {
      FSM_IDLE  = ST_IDLE,
      FSM_WORK  = ST_WORK,
      FSM_DONE  = ST_DONE,
      FSM_DIV0  = ST_DIV0,
      FSM_ROUND = 3'd4
   } fsm_e;

   // Bits needed to count down from n-1 to 0.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frac_div_if.sv
// rtl/frac_div_if.sv - start/state handshake and operand bus of the frac_div stage
// Purpose : groups the handshake and data signals of the divider.
// Signals : start_i (level start), num_bi/den_bi (operands),
//           state_o (IDLE/WORK/DONE/DIV0), q_bo (Q.FRAC quotient), r_bo (remainder).
// Modports: master drives start/operands, slave (the divider) drives results.
interface frac_div_if #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 8
) ();
   import frac_div_pkg::*;

   logic                  start_i;
   logic [WIDTH-1:0]      num_bi;
   logic [WIDTH-1:0]      den_bi;
   logic [STATE_W-1:0]    state_o;
   logic [WIDTH+FRAC-1:0] q_bo;
   logic [WIDTH-1:0]      r_bo;

   modport master (
      output start_i, num_bi, den_bi,
      input  state_o, q_bo, r_bo
   );

   modport slave (
      input  start_i, num_bi, den_bi,
      output state_o, q_bo, r_bo
   );

endinterface

// File: rtl/frac_div_step.sv
// rtl/frac_div_step.sv - one combinational restoring-division step
// Purpose : shifts one dividend bit into the partial remainder and subtracts
//           the denominator when it fits.
// Ports   : rem_i (partial remainder, always < den_i), bit_i (next dividend
//           bit), den_i (denominator), rem_o (new remainder), q_o (quotient bit).
module frac_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] den_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   // One extra bit holds the carry out of the shift.
   logic [WIDTH:0] trial;

   assign trial = {rem_i, bit_i};
   assign q_o   = (trial >= {1'b0, den_i});

   // When the subtraction happens the result is < den_i, so the low WIDTH
   // bits of the modular difference are exact.
   assign rem_o = q_o ? (trial[WIDTH-1:0] - den_i) : trial[WIDTH-1:0];

endmodule

// File: rtl/frac_div.sv
// rtl/frac_div.sv - iterative restoring divider producing (num << FRAC) / den
// Purpose : Q(WIDTH).(FRAC) ratio, one quotient bit per clock, start/state
//           handshake shared with the square and root stages.
// Ports   : clk_i (rising edge), rst_i (async, active-low),
//           bus (frac_div_if.slave: start_i, num_bi, den_bi -> state_o, q_bo, r_bo).
// Config  : FRAC_DIV_ROUND_EN adds a round-half-up cycle before DONE
//           (latency WIDTH+FRAC+1); undefined gives truncation, latency WIDTH+FRAC.
module frac_div
   import frac_div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int FRAC  = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   frac_div_if.slave bus
);

   localparam int N     = WIDTH + FRAC;
   localparam int CNT_W = cnt_width(N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   fsm_e             state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     dvd_q, dvd_d;   // dividend, consumed MSB first
   logic [WIDTH-1:0] den_q, den_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [N-1:0]     q_q, q_d;

   logic [WIDTH-1:0] step_rem;
   logic             step_bit;

   frac_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i (rem_q),
      .bit_i (dvd_q[N-1]),
      .den_i (den_q),
      .rem_o (step_rem),
      .q_o   (step_bit)
   );

`ifdef FRAC_DIV_ROUND_EN
   // Round half up on the final remainder; an all-ones quotient saturates.
   logic round_up;
   assign round_up = ({rem_q, 1'b0} >= {1'b0, den_q}) && !(&q_q);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      den_d   = den_q;
      rem_d   = rem_q;
      q_d     = q_q;

      case (state_q)
         FSM_IDLE: begin
            if (bus.start_i) begin
               dvd_d = {bus.num_bi, {FRAC{1'b0}}};
               den_d = bus.den_bi;
               rem_d = '0;
               if (bus.den_bi == '0) begin
                  state_d = FSM_DIV0;
                  q_d     = '1;
                  cnt_d   = '0;
               end else begin
                  state_d = FSM_WORK;
                  q_d     = '0;
                  cnt_d   = CNT_LAST;
               end
            end
         end

         FSM_WORK: begin
            rem_d = step_rem;
            q_d   = {q_q[N-2:0], step_bit};
            dvd_d = {dvd_q[N-2:0], 1'b0};
            if (cnt_q == '0) begin
`ifdef FRAC_DIV_ROUND_EN
               state_d = FSM_ROUND;
`else
               state_d = FSM_DONE;
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

`ifdef FRAC_DIV_ROUND_EN
         FSM_ROUND: begin
            if (round_up) begin
               q_d = q_q + N'(1);
            end
            state_d = FSM_DONE;
         end
`endif

         // Results are held; a fresh launch needs start_i low for one edge.
         FSM_DONE, FSM_DIV0: begin
            if (!bus.start_i) begin
               state_d = FSM_IDLE;
            end
         end

         default: begin
            state_d = FSM_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= FSM_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         den_q   <= '0;
         rem_q   <= '0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         den_q   <= den_d;
         rem_q   <= rem_d;
         q_q     <= q_d;
      end
   end

   assign bus.state_o = (state_q == FSM_ROUND) ? ST_WORK : state_q;
   assign bus.q_bo    = q_q;
   assign bus.r_bo    = rem_q;

endmodule

// File: tb/tb_frac_div.sv
// tb/tb_frac_div.sv - self-checking bench for frac_div (default or FRAC_DIV_ROUND_EN build)
module tb_frac_div;
   import frac_div_pkg::*;

   localparam int WIDTH = 32;
   localparam int FRAC  = 8;
   localparam int N     = WIDTH + FRAC;
`ifdef FRAC_DIV_ROUND_EN
   localparam bit ROUND = 1'b1;
   localparam int LAT   = N + 1;
`else
   localparam bit ROUND = 1'b0;
   localparam int LAT   = N;
`endif
   localparam logic [N-1:0] Q_MAX = {N{1'b1}};

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   frac_div_if #(.WIDTH(WIDTH), .FRAC(FRAC)) bus ();

   frac_div #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus.slave)
   );

   // ---------------- behavioural model ----------------
   logic [2:0]       m_state;
   logic [N-1:0]     m_q;
   logic [WIDTH-1:0] m_r;
   int               m_left;

   function automatic logic [N-1:0] model_q(input logic [WIDTH-1:0] num, input logic [WIDTH-1:0] den);
      longint unsigned d, q, r;
      d = longint'(num) << FRAC;
      q = d / longint'(den);
      r = d % longint'(den);
      if (ROUND && (2 * r >= longint'(den)) && (q != longint'(Q_MAX))) q = q + 1;
      return q[N-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] model_r(input logic [WIDTH-1:0] num, input logic [WIDTH-1:0] den);
      longint unsigned d;
      d = longint'(num) << FRAC;
      return WIDTH'(d % longint'(den));
   endfunction

   function automatic int isqrt(input int x);
      int y = 0;
      while ((y + 1) * (y + 1) <= x) y++;
      return y;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state <= ST_IDLE;
         m_q     <= '0;
         m_r     <= '0;
         m_left  <= 0;
      end else begin
         case (m_state)
            ST_IDLE: if (bus.start_i) begin
               if (bus.den_bi == '0) begin
                  m_state <= ST_DIV0;
                  m_q     <= Q_MAX;
                  m_r     <= '0;
               end else begin
                  m_state <= ST_WORK;
                  m_left  <= LAT - 1;
                  m_q     <= model_q(bus.num_bi, bus.den_bi);
                  m_r     <= model_r(bus.num_bi, bus.den_bi);
               end
            end
            ST_WORK: begin
               if (m_left == 0) m_state <= ST_DONE;
               else m_left <= m_left - 1;
            end
            default: if (!bus.start_i) m_state <= ST_IDLE;
         endcase
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_done(output int edges);
      edges = 0;
      while (edges < 200) begin
         @(negedge clk);
         edges++;
         if (bus.state_o == ST_DONE) break;
      end
   endtask

   // Pulse start for one edge, scramble operands afterwards, then check results.
   task automatic run_op(input string name, input logic [WIDTH-1:0] num, input logic [WIDTH-1:0] den,
                         input logic [N-1:0] q_trunc, input logic [N-1:0] q_round,
                         input logic [WIDTH-1:0] rem);
      int edges;
      @(negedge clk);
      bus.num_bi  = num;
      bus.den_bi  = den;
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.num_bi  = ~num;
      bus.den_bi  = den + 32'd3;
      wait_done(edges);
      check({name, "_latency"}, 64'(edges), 64'(LAT));
      check({name, "_q"}, 64'(bus.q_bo), 64'(ROUND ? q_round : q_trunc));
      check({name, "_r"}, 64'(bus.r_bo), 64'(rem));
      @(negedge clk);
      check({name, "_idle"}, 64'(bus.state_o), 64'(ST_IDLE));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int edges;
      int root;
      rst_n       = 1'b0;
      bus.start_i = 1'b0;
      bus.num_bi  = '0;
      bus.den_bi  = '0;

      fork
         forever begin
            @(negedge clk);
            if (rst_n) begin
               check("cmp_state", 64'(bus.state_o), 64'(m_state));
               if (m_state == ST_DONE || m_state == ST_DIV0) begin
                  check("cmp_q", 64'(bus.q_bo), 64'(m_q));
                  check("cmp_r", 64'(bus.r_bo), 64'(m_r));
               end
            end
         end
      join_none

      repeat (2) @(negedge clk);
      check("rst_state", 64'(bus.state_o), 64'(ST_IDLE));
      check("rst_q", 64'(bus.q_bo), 64'd0);
      check("rst_r", 64'(bus.r_bo), 64'd0);
      #1 rst_n = 1'b1;

      run_op("d3_5",   32'd3,          32'd5, 40'd153,          40'd154,          32'd3);
      run_op("d5_5",   32'd5,          32'd5, 40'd256,          40'd256,          32'd0);
      run_op("d0_7",   32'd0,          32'd7, 40'd0,            40'd0,            32'd0);
      run_op("dmax_1", 32'hFFFFFFFF,   32'd1, 40'hFFFFFFFF00,   40'hFFFFFFFF00,   32'd0);
      run_op("d1_3",   32'd1,          32'd3, 40'd85,           40'd85,           32'd1);
      run_op("d2_3",   32'd2,          32'd3, 40'd170,          40'd171,          32'd2);
      run_op("d100_7", 32'd100,        32'd7, 40'd3657,         40'd3657,         32'd1);

      // Divide by zero with start held high: stays in DIV0 until start drops.
      @(negedge clk);
      bus.num_bi  = 32'd9;
      bus.den_bi  = 32'd0;
      bus.start_i = 1'b1;
      @(negedge clk);
      check("div0_state", 64'(bus.state_o), 64'(ST_DIV0));
      check("div0_q", 64'(bus.q_bo), 64'hFF_FFFF_FFFF);
      check("div0_r", 64'(bus.r_bo), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("div0_hold", 64'(bus.state_o), 64'(ST_DIV0));
      end
      bus.start_i = 1'b0;
      @(negedge clk);
      check("div0_exit", 64'(bus.state_o), 64'(ST_IDLE));

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      bus.num_bi  = 32'd3;
      bus.den_bi  = 32'd5;
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (20) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_state", 64'(bus.state_o), 64'(ST_IDLE));
      check("async_rst_q", 64'(bus.q_bo), 64'd0);
      check("async_rst_r", 64'(bus.r_bo), 64'd0);
      // Start is already high when reset releases mid-cycle: the next edge launches.
      bus.num_bi  = 32'd4;
      bus.den_bi  = 32'd5;
      bus.start_i = 1'b1;
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      wait_done(edges);
      check("rst_restart_latency", 64'(edges), 64'(LAT));
      check("rst_restart_q", 64'(bus.q_bo), ROUND ? 64'd205 : 64'd204);
      check("rst_restart_r", 64'(bus.r_bo), 64'd4);
      @(negedge clk);

      // Root stage result feeding den; start held high through DONE.
      root = isqrt(25);
      @(negedge clk);
      bus.num_bi  = 32'd3;
      bus.den_bi  = 32'(root);
      bus.start_i = 1'b1;
      @(negedge clk);
      wait_done(edges);
      check("chain_latency", 64'(edges), 64'(LAT));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("chain_hold_state", 64'(bus.state_o), 64'(ST_DONE));
         check("chain_hold_q", 64'(bus.q_bo), ROUND ? 64'd154 : 64'd153);
      end
      bus.start_i = 1'b0;
      @(negedge clk);
      check("chain_exit", 64'(bus.state_o), 64'(ST_IDLE));

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
